zapper_shot_controller: RTL and testbench

- Sequences one light-gun shot.
- On a debounced trigger press it:
  - waits for a frame boundary;
  - commands the pattern generator to show black frame(s), then target frame(s);
  - samples the photodiode in each phase;
  - reports hit or miss;
  - enforces a cooldown and a per-round shot budget.
- Sits between the VGA timing block (frame_start) and pattern_gen (display_mode).

---
 rtl/zapper_shot_controller.sv | 250 +++++++++++++++++++++++++
 tb/tb_zapper_shot_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zapper_shot_controller.sv
// -----------------------------------------------------------------------------
// zapper_shot_controller
//
// Purpose: sequences one light-gun shot. A debounced trigger press waits for a
// frame boundary, then has the pattern generator show black frame(s) followed
// by target frame(s) while the photodiode is sampled in each phase. The shot
// scores a hit only if light was seen during the target phase and none during
// the black phase. A cooldown and a per-round shot budget follow each shot.
//
// Ports:
//   clk          pixel clock (single clock domain)
//   reset        synchronous, active-high reset
//   trigger      raw gun trigger (asynchronous, active-high)
//   sensor       raw photodiode (asynchronous, high = light)
//   frame_start  one-cycle pulse at the first cycle of each frame
//   round_start  one-cycle pulse, reloads the shot budget
//   display_mode 0 = normal, 1 = black, 2 = target (registered)
//   hit / miss   one-cycle result pulses (exactly one per shot)
//   shots_left   remaining shots this round
//   busy         high whenever a shot is in progress (state != IDLE)
// -----------------------------------------------------------------------------
module zapper_shot_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BLACK_FRAMES    = 1,
  parameter int TARGET_FRAMES   = 1,
  parameter int SHOTS           = 3,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic       sensor,
  input  logic       frame_start,
  input  logic       round_start,
  output logic [1:0] display_mode,
  output logic       hit,
  output logic       miss,
  output logic [1:0] shots_left,
  output logic       busy
);

  localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int MAXF = (BLACK_FRAMES > TARGET_FRAMES)
                      ? ((BLACK_FRAMES > COOLDOWN_FRAMES) ? BLACK_FRAMES : COOLDOWN_FRAMES)
                      : ((TARGET_FRAMES > COOLDOWN_FRAMES) ? TARGET_FRAMES : COOLDOWN_FRAMES);
  localparam int FW   = $clog2(MAXF + 1);

  localparam logic [1:0]     SHOTS_FULL = 2'(SHOTS);
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0]  BLACK_LAST = FW'(BLACK_FRAMES - 1);
  localparam logic [FW-1:0]  TGT_LAST   = FW'(TARGET_FRAMES - 1);
  localparam logic [FW-1:0]  COOL_LAST  = FW'(COOLDOWN_FRAMES - 1);

  localparam logic [1:0] DISP_NORMAL = 2'd0;
  localparam logic [1:0] DISP_BLACK  = 2'd1;
  localparam logic [1:0] DISP_TARGET = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_BLACK,
    S_TARGET,
    S_RESULT,
    S_COOLDOWN
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic r_trig_s1, r_trig_s2;
  logic r_sens_s1, r_sens_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_trig_s1 <= 1'b0;
      r_trig_s2 <= 1'b0;
      r_sens_s1 <= 1'b0;
      r_sens_s2 <= 1'b0;
    end else begin
      r_trig_s1 <= trigger;
      r_trig_s2 <= r_trig_s1;
      r_sens_s1 <= sensor;
      r_sens_s2 <= r_sens_s1;
    end
  end

  logic w_trig_sync, w_sensor_sync;
  assign w_trig_sync   = r_trig_s2;
  assign w_sensor_sync = r_sens_s2;

  // ---------------------------------------------------------------------------
  // Trigger debouncer: the debounced level only follows the synced trigger
  // after it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
  // ---------------------------------------------------------------------------
  logic [DBW-1:0] r_db_cnt;
  logic           r_trig_db;
  logic           r_trig_db_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_db_cnt    <= '0;
      r_trig_db   <= 1'b0;
      r_trig_db_q <= 1'b0;
    end else begin
      r_trig_db_q <= r_trig_db;
      if (w_trig_sync != r_trig_db) begin
        if (r_db_cnt == DB_LAST) begin
          r_trig_db <= w_trig_sync;
          r_db_cnt  <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DBW'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  logic w_shot_req;
  assign w_shot_req = r_trig_db & ~r_trig_db_q;

  // ---------------------------------------------------------------------------
  // Shot sequencer
  // ---------------------------------------------------------------------------
  state_t        r_state, w_state_next;
  logic [FW-1:0] r_frame_cnt, w_frame_cnt_next;
  logic          r_black_seen, w_black_seen_next;
  logic          r_target_seen, w_target_seen_next;
  logic [1:0]    r_shots_left, w_shots_left_next;
  logic [1:0]    r_display, w_display_next;
  logic          r_hit, w_hit_next;
  logic          r_miss, w_miss_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_frame_cnt   <= '0;
      r_black_seen  <= 1'b0;
      r_target_seen <= 1'b0;
      r_shots_left  <= SHOTS_FULL;
      r_display     <= DISP_NORMAL;
      r_hit         <= 1'b0;
      r_miss        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_frame_cnt   <= w_frame_cnt_next;
      r_black_seen  <= w_black_seen_next;
      r_target_seen <= w_target_seen_next;
      r_shots_left  <= w_shots_left_next;
      r_display     <= w_display_next;
      r_hit         <= w_hit_next;
      r_miss        <= w_miss_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_frame_cnt_next   = r_frame_cnt;
    w_black_seen_next  = r_black_seen;
    w_target_seen_next = r_target_seen;
    // A reload wins over every decrement except a shot accepted in IDLE,
    // which consumes one shot from the freshly reloaded budget.
    w_shots_left_next  = round_start ? SHOTS_FULL : r_shots_left;
    w_hit_next         = 1'b0;
    w_miss_next        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_shot_req && (round_start || (r_shots_left != 2'd0))) begin
          w_state_next       = S_ARM;
          w_shots_left_next  = round_start ? (SHOTS_FULL - 2'd1) : (r_shots_left - 2'd1);
          w_black_seen_next  = 1'b0;
          w_target_seen_next = 1'b0;
        end
      end

      // Entry happens from IDLE, so any frame_start seen here is strictly
      // after acceptance.
      S_ARM: begin
        if (frame_start) begin
          w_state_next     = S_BLACK;
          w_frame_cnt_next = '0;
        end
      end

      S_BLACK: begin
        w_black_seen_next = r_black_seen | w_sensor_sync;
        if (frame_start) begin
          if (r_frame_cnt == BLACK_LAST) begin
            w_state_next     = S_TARGET;
            w_frame_cnt_next = '0;
          end else begin
            w_frame_cnt_next = r_frame_cnt + FW'(1);
          end
        end
      end

      S_TARGET: begin
        w_target_seen_next = r_target_seen | w_sensor_sync;
        if (frame_start) begin
          if (r_frame_cnt == TGT_LAST) begin
            w_state_next     = S_RESULT;
            w_frame_cnt_next = '0;
          end else begin
            w_frame_cnt_next = r_frame_cnt + FW'(1);
          end
        end
      end

      // Light during the black phase means the gun is pointed at a lamp,
      // so it forces a miss.
      S_RESULT: begin
        w_hit_next       = r_target_seen & ~r_black_seen;
        w_miss_next      = ~(r_target_seen & ~r_black_seen);
        w_state_next     = S_COOLDOWN;
        w_frame_cnt_next = '0;
      end

      S_COOLDOWN: begin
        if (frame_start) begin
          if (r_frame_cnt == COOL_LAST) begin
            w_state_next     = S_IDLE;
            w_frame_cnt_next = '0;
          end else begin
            w_frame_cnt_next = r_frame_cnt + FW'(1);
          end
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Display follows the next state so it changes in the cycle right after
    // the frame_start that moved the sequencer.
    case (w_state_next)
      S_BLACK:  w_display_next = DISP_BLACK;
      S_TARGET: w_display_next = DISP_TARGET;
      default:  w_display_next = DISP_NORMAL;
    endcase
  end

  assign display_mode = r_display;
  assign hit          = r_hit;
  assign miss         = r_miss;
  assign shots_left   = r_shots_left;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_zapper_shot_controller.sv
// -----------------------------------------------------------------------------
// tb_zapper_shot_controller
//
// Purpose: self-checking bench for zapper_shot_controller with a short
// debounce and cooldown. A table of shot scenarios is applied in a loop,
// followed by hand-written sequences for frame-boundary acceptance, a press
// during cooldown, a mid-shot budget reload and a reset during TARGET.
// Frames are 100 cycles long.
// -----------------------------------------------------------------------------
module tb_zapper_shot_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       trigger = 1'b0;
  logic       sensor = 1'b0;
  logic       frame_start = 1'b0;
  logic       round_start = 1'b0;
  logic [1:0] display_mode;
  logic       hit;
  logic       miss;
  logic [1:0] shots_left;
  logic       busy;

  zapper_shot_controller #(
    .DEBOUNCE_CYCLES(4),
    .BLACK_FRAMES(1),
    .TARGET_FRAMES(1),
    .SHOTS(3),
    .COOLDOWN_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .trigger(trigger),
    .sensor(sensor),
    .frame_start(frame_start),
    .round_start(round_start),
    .display_mode(display_mode),
    .hit(hit),
    .miss(miss),
    .shots_left(shots_left),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Sensor behaviour: 0 dark, 1 lit only while target shown,
  // 2 always lit (lamp), 3 lit only while black shown.
  int sens_mode = 0;
  int phase = 0;

  int total = 0;
  int passed = 0;

  int hit_cnt, miss_cnt, d1_cnt, d2_cnt, cool_cnt;
  bit busy_seen, pulse_seen;
  bit bad_seen = 1'b0;

  typedef struct {
    int sens_mode;
    int trig_len;
    bit bounce;
    bit do_round;
    bit exp_busy;
    int exp_hit;
    int exp_miss;
    int exp_shots;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clear_obs();
    hit_cnt = 0; miss_cnt = 0; d1_cnt = 0; d2_cnt = 0; cool_cnt = 0;
    busy_seen = 1'b0; pulse_seen = 1'b0;
  endtask

  // Advance one cycle: sample outputs at the falling edge, then drive inputs.
  task automatic tick();
    @(negedge clk);
    if (hit) hit_cnt++;
    if (miss) miss_cnt++;
    if (hit || miss) pulse_seen = 1'b1;
    if (pulse_seen && busy) cool_cnt++;
    if (display_mode == 2'd1) d1_cnt++;
    if (display_mode == 2'd2) d2_cnt++;
    if (busy) busy_seen = 1'b1;
    if (display_mode == 2'd3 || (hit && miss)) bad_seen = 1'b1;
    round_start = 1'b0;
    phase = (phase == 99) ? 0 : phase + 1;
    frame_start = (phase == 0);
    case (sens_mode)
      1:       sensor = (display_mode == 2'd2);
      2:       sensor = 1'b1;
      3:       sensor = (display_mode == 2'd1);
      default: sensor = 1'b0;
    endcase
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 100 && phase != p; i++) tick();
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit done;
    clear_obs();
    sens_mode = v.sens_mode;
    if (v.do_round) begin
      round_start = 1'b1;
      tick();
    end
    wait_phase(10);
    for (int i = 0; i < v.trig_len; i++) begin
      trigger = v.bounce ? (((i / 2) % 2) == 0) : 1'b1;
      tick();
    end
    trigger = 1'b0;
    done = 1'b0;
    if (v.exp_busy) begin
      for (int i = 0; i < 700 && !done; i++) begin
        tick();
        if (busy_seen && !busy) done = 1'b1;
      end
      chk($sformatf("vec%0d_done", idx), int'(done), 1);
    end else begin
      repeat (300) tick();
    end
    chk($sformatf("vec%0d_busy", idx), int'(busy_seen), int'(v.exp_busy));
    chk($sformatf("vec%0d_hit", idx), hit_cnt, v.exp_hit);
    chk($sformatf("vec%0d_miss", idx), miss_cnt, v.exp_miss);
    chk($sformatf("vec%0d_shots", idx), int'(shots_left), v.exp_shots);
    chk($sformatf("vec%0d_black_cycles", idx), d1_cnt, v.exp_busy ? 100 : 0);
    chk($sformatf("vec%0d_target_cycles", idx), d2_cnt, v.exp_busy ? 100 : 0);
    chk($sformatf("vec%0d_cooldown_cycles", idx), cool_cnt, v.exp_busy ? 199 : 0);
    $display("vec%0d: mode=%0d hit=%0d miss=%0d shots_left=%0d", idx, v.sens_mode,
             hit_cnt, miss_cnt, shots_left);
  endtask

  initial begin
    bit ok;
    //          mode len bnc rnd busy hit miss shots
    vecs[0] = '{1, 10, 1'b0, 1'b0, 1'b1, 1, 0, 2};  // clean hit
    vecs[1] = '{2, 10, 1'b0, 1'b0, 1'b1, 0, 1, 1};  // lamp cheat
    vecs[2] = '{1, 20, 1'b1, 1'b0, 1'b0, 0, 0, 1};  // bouncing trigger
    vecs[3] = '{0, 10, 1'b0, 1'b0, 1'b1, 0, 1, 0};  // dark miss, budget spent
    vecs[4] = '{1, 10, 1'b0, 1'b0, 1'b0, 0, 0, 0};  // no shots left
    vecs[5] = '{3, 10, 1'b0, 1'b1, 1'b1, 0, 1, 2};  // reload, then black-only light

    // Reset state
    clear_obs();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_display", int'(display_mode), 0);
    chk("reset_hit", int'(hit), 0);
    chk("reset_miss", int'(miss), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_shots", int'(shots_left), 3);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Acceptance coincident with frame_start: must wait a full frame in ARM.
    clear_obs();
    sens_mode = 0;
    wait_phase(94);
    trigger = 1'b1;
    repeat (7) tick();
    chk("edge_accept_busy", int'(busy), 1);
    chk("edge_accept_display", int'(display_mode), 0);
    repeat (3) tick();
    trigger = 1'b0;
    wait_phase(50);
    round_start = 1'b1;
    tick();
    tick();
    chk("reload_in_arm_shots", int'(shots_left), 3);
    chk("reload_in_arm_busy", int'(busy), 1);
    wait_phase(0);
    chk("arm_holds_display", int'(display_mode), 0);
    tick();
    chk("black_after_frame", int'(display_mode), 1);
    $display("edge: accepted on frame_start, black one frame later, shots_left=%0d", shots_left);

    // Press during COOLDOWN is dropped.
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      ok = pulse_seen;
    end
    chk("cooldown_pulse_seen", int'(ok), 1);
    chk("cooldown_shot_miss", miss_cnt, 1);
    repeat (5) tick();
    trigger = 1'b1;
    repeat (10) tick();
    trigger = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      ok = !busy;
    end
    chk("cooldown_ends", int'(ok), 1);
    busy_seen = 1'b0;
    repeat (300) tick();
    chk("cooldown_press_dropped", int'(busy_seen), 0);
    chk("cooldown_press_shots", int'(shots_left), 3);
    $display("cooldown: press dropped, busy_seen=%0d shots_left=%0d", busy_seen, shots_left);

    // Reset during TARGET.
    clear_obs();
    sens_mode = 1;
    trigger = 1'b1;
    repeat (10) tick();
    trigger = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      ok = (display_mode == 2'd2);
    end
    chk("reached_target", int'(ok), 1);
    chk("shots_before_reset", int'(shots_left), 2);
    repeat (20) tick();
    clear_obs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sens_mode = 0;
    chk("midreset_display", int'(display_mode), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_shots", int'(shots_left), 3);
    repeat (50) tick();
    chk("midreset_no_pulse", hit_cnt + miss_cnt, 0);
    $display("reset: display=%0d busy=%0d shots_left=%0d", display_mode, busy, shots_left);

    chk("no_illegal_outputs", int'(bad_seen), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
